// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single external memory port between the instruction-fetch
//   requester (imem, read-only) and the load/store requester (dmem).
//   A three-state FSM grants one requester at a time. Ties alternate
//   round-robin. All memory-side signals are registered. A per-transaction
//   timeout aborts a transaction when memory never answers.
//
// Handshake: a requester raises *_req with stable address/data and holds it
//   until its *_ready pulses for one cycle. *_rdata is valid only in that
//   cycle. The arbiter ignores a requester's req while that requester's ready
//   is high, so a slow deassert cannot cause a second grant. On the memory
//   side, mem_re/mem_wr stay high until mem_ready pulses for one cycle, or
//   until TIMEOUT cycles pass.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   imem_req/addr      fetch request and address
//   imem_rdata/ready   fetched word and completion pulse
//   dmem_req/we/addr/wdata  load/store request
//   dmem_rdata/ready   load data and completion pulse
//   mem_addr/data_in/wr/re  registered memory-side command
//   mem_data_out/ready memory read data and completion pulse
//   dmem_owns          high while a dmem transaction holds the bus
//   bus_err            pulses with the owner's ready when the transaction timed out
//   dbg_state_o        current FSM state, for debug and checkers
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_req,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_rdata,
   output logic        imem_ready,
   input  logic        dmem_req,
   input  logic        dmem_we,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_in,
   output logic        mem_wr,
   output logic        mem_re,
   input  logic [31:0] mem_data_out,
   input  logic        mem_ready,
   output logic        dmem_owns,
   output logic        bus_err,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      IMEM_BUSY = 2'd1,
      DMEM_BUSY = 2'd2
   } state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic        last_dmem_q, last_dmem_d;   // 1 = dmem owned the bus last
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_din_q, mem_din_d;
   logic        mem_wr_q, mem_wr_d;
   logic        mem_re_q, mem_re_d;
   logic        owns_q, owns_d;
   logic        i_rdy_q, i_rdy_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic        d_rdy_q, d_rdy_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        err_q, err_d;

   logic        i_eff, d_eff, grant_d, grant_i, done, tmo;

   // A requester whose ready is high this cycle is finishing; mask its req.
   assign i_eff = imem_req & ~i_rdy_q;
   assign d_eff = dmem_req & ~d_rdy_q;

   // On a tie the requester that did not own the bus last wins.
   assign grant_d = d_eff & (~i_eff | ~last_dmem_q);
   assign grant_i = i_eff & ~grant_d;

   // mem_ready wins over a timeout that lands on the same cycle.
   assign done = mem_ready;
   assign tmo  = ~mem_ready & ((cnt_q + 8'd1) == TMO);

   always_comb begin
      state_d     = state_q;
      last_dmem_d = last_dmem_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      mem_wr_d    = mem_wr_q;
      mem_re_d    = mem_re_q;
      owns_d      = owns_q;
      i_rdy_d     = 1'b0;
      i_rdata_d   = 32'd0;
      d_rdy_d     = 1'b0;
      d_rdata_d   = 32'd0;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d     = DMEM_BUSY;
               mem_addr_d  = dmem_addr;
               mem_din_d   = dmem_wdata;
               mem_re_d    = ~dmem_we;
               mem_wr_d    = dmem_we;
               owns_d      = 1'b1;
               last_dmem_d = 1'b1;
               cnt_d       = 8'd0;
            end else if (grant_i) begin
               state_d     = IMEM_BUSY;
               mem_addr_d  = imem_addr;
               mem_re_d    = 1'b1;
               mem_wr_d    = 1'b0;
               owns_d      = 1'b0;
               last_dmem_d = 1'b0;
               cnt_d       = 8'd0;
            end
         end
         IMEM_BUSY, DMEM_BUSY: begin
            if (done || tmo) begin
               state_d  = IDLE;
               mem_re_d = 1'b0;
               mem_wr_d = 1'b0;
               owns_d   = 1'b0;
               err_d    = tmo;
               if (state_q == IMEM_BUSY) begin
                  i_rdy_d   = 1'b1;
                  i_rdata_d = done ? mem_data_out : 32'd0;
               end else begin
                  d_rdy_d   = 1'b1;
                  // Stores return zero; a load returns memory data.
                  d_rdata_d = (done && !mem_wr_q) ? mem_data_out : 32'd0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         last_dmem_q <= 1'b0;
         cnt_q       <= 8'd0;
         mem_addr_q  <= 32'd0;
         mem_din_q   <= 32'd0;
         mem_wr_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         owns_q      <= 1'b0;
         i_rdy_q     <= 1'b0;
         i_rdata_q   <= 32'd0;
         d_rdy_q     <= 1'b0;
         d_rdata_q   <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_dmem_q <= last_dmem_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         mem_wr_q    <= mem_wr_d;
         mem_re_q    <= mem_re_d;
         owns_q      <= owns_d;
         i_rdy_q     <= i_rdy_d;
         i_rdata_q   <= i_rdata_d;
         d_rdy_q     <= d_rdy_d;
         d_rdata_q   <= d_rdata_d;
         err_q       <= err_d;
      end
   end

   assign imem_rdata  = i_rdata_q;
   assign imem_ready  = i_rdy_q;
   assign dmem_rdata  = d_rdata_q;
   assign dmem_ready  = d_rdy_q;
   assign mem_addr    = mem_addr_q;
   assign mem_data_in = mem_din_q;
   assign mem_wr      = mem_wr_q;
   assign mem_re      = mem_re_q;
   assign dmem_owns   = owns_q;
   assign bus_err     = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (TIMEOUT = 4).
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, so each sample shows the result of the edge just passed.
module tb_mem_bus_arbiter;

   logic        clk, rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   logic [31:0] mem_addr, mem_data_in;
   logic        mem_wr, mem_re;
   logic [31:0] mem_data_out;
   logic        mem_ready;
   logic        dmem_owns, bus_err;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   mem_bus_arbiter #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_ready   (imem_ready),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_ready   (dmem_ready),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_wr       (mem_wr),
      .mem_re       (mem_re),
      .mem_data_out (mem_data_out),
      .mem_ready    (mem_ready),
      .dmem_owns    (dmem_owns),
      .bus_err      (bus_err),
      .dbg_state_o  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      imem_req = 1'b0; imem_addr = 32'd0;
      dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = 32'd0; dmem_wdata = 32'd0;
      mem_data_out = 32'd0; mem_ready = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      step();
      step();
      #3 rst = 1'b1;
   endtask

   // {re, wr, owns, i_rdy, d_rdy, err, addr, din, irdata, drdata}
   function automatic logic [133:0] obs();
      return {mem_re, mem_wr, dmem_owns, imem_ready, dmem_ready, bus_err,
              mem_addr, mem_data_in, imem_rdata, dmem_rdata};
   endfunction

   task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [31:0] m_data;
      logic        m_rdy;
      logic [5:0]  e_flags;   // re, wr, owns, i_rdy, d_rdy, err
      logic [31:0] e_addr;
      logic [31:0] e_din;
      logic [31:0] e_irdata;
      logic [31:0] e_drdata;
   } vec_t;

   vec_t vecs[13];

   // scoreboard of expected grants {dmem_owns, mem_addr}
   logic [32:0] exp_q[$];

   initial begin
      int hi_cnt;
      int rise_cnt;
      logic prev_strobe;
      logic [32:0] exp_g;

      // fetch: mem_ready arrives 3 cycles after mem_re rises
      vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                   6'b100000, 32'h100, 32'h0, 32'h0, 32'h0};
      vecs[1]  = vecs[0];
      vecs[2]  = vecs[0];
      vecs[3]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h00500093, 1'b1,
                   6'b000100, 32'h100, 32'h0, 32'h00500093, 32'h0};
      vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                   6'b000000, 32'h100, 32'h0, 32'h0, 32'h0};
      // store: memory data must not leak into dmem_rdata
      vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 32'h0, 1'b0,
                   6'b011000, 32'h2000, 32'hDEADBEEF, 32'h0, 32'h0};
      vecs[6]  = vecs[5];
      vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 32'h12345678, 1'b1,
                   6'b000010, 32'h2000, 32'hDEADBEEF, 32'h0, 32'h0};
      vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                   6'b000000, 32'h2000, 32'hDEADBEEF, 32'h0, 32'h0};
      // load, latency 1, requester slow to drop req (masked), then stray mem_ready
      vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h55, 32'h0, 1'b0,
                   6'b101000, 32'h3000, 32'h55, 32'h0, 32'h0};
      vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h55, 32'hCAFEF00D, 1'b1,
                   6'b000010, 32'h3000, 32'h55, 32'h0, 32'hCAFEF00D};
      vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h55, 32'h0, 1'b0,
                   6'b000000, 32'h3000, 32'h55, 32'h0, 32'h0};
      vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h9999, 1'b1,
                   6'b000000, 32'h3000, 32'h55, 32'h0, 32'h0};

      idle_inputs();
      rst = 1'b0;
      #2;
      check("reset_async", obs(), 134'd0);
      apply_reset();
      step();
      check("reset_state", obs(), 134'd0);

      // ---------------- table run ----------------
      for (int i = 0; i < 13; i++) begin
         imem_req = vecs[i].i_req;  imem_addr = vecs[i].i_addr;
         dmem_req = vecs[i].d_req;  dmem_we = vecs[i].d_we;
         dmem_addr = vecs[i].d_addr; dmem_wdata = vecs[i].d_wdata;
         mem_data_out = vecs[i].m_data; mem_ready = vecs[i].m_rdy;
         step();
         check($sformatf("vec%0d", i), obs(),
               {vecs[i].e_flags, vecs[i].e_addr, vecs[i].e_din,
                vecs[i].e_irdata, vecs[i].e_drdata});
      end

      // ---------------- contention from reset ----------------
      idle_inputs();
      apply_reset();
      imem_req = 1'b1; imem_addr = 32'h10;
      dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h20;
      mem_data_out = 32'h0BAD0BAD;
      exp_q.push_back({1'b1, 32'h20});
      exp_q.push_back({1'b0, 32'h10});
      exp_q.push_back({1'b1, 32'h20});
      exp_q.push_back({1'b0, 32'h10});
      prev_strobe = 1'b0;
      rise_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if ((mem_re | mem_wr) && !prev_strobe) begin
            if (exp_q.size() == 0) begin
               check("cont_extra_grant", {101'd0, dmem_owns, mem_addr}, 134'd0);
            end else begin
               exp_g = exp_q.pop_front();
               check($sformatf("cont_grant%0d", rise_cnt), {101'd0, dmem_owns, mem_addr},
                     {101'd0, exp_g});
               check($sformatf("cont_cycle%0d", rise_cnt), 134'(c), 134'(2 * rise_cnt));
            end
            rise_cnt++;
         end
         prev_strobe = mem_re | mem_wr;
         mem_ready = mem_re | mem_wr;   // memory latency 1
      end
      check("cont_grant_count", 134'(rise_cnt), 134'd4);
      idle_inputs();
      step();
      step();

      // ---------------- timeout ----------------
      imem_req = 1'b1; imem_addr = 32'h40; mem_data_out = 32'hFFFFFFFF;
      hi_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (imem_ready) break;
         if (mem_re) hi_cnt++;
      end
      check("tmo_re_cycles", 134'(hi_cnt), 134'd4);
      check("tmo_exit", {130'd0, imem_ready, bus_err, mem_re, dmem_ready} , {130'd0, 4'b1100});
      check("tmo_rdata", 134'(imem_rdata), 134'd0);
      imem_req = 1'b0;
      step();
      check("tmo_err_pulse", {132'd0, bus_err, imem_ready}, 134'd0);
      // follow-up request is served normally
      imem_req = 1'b1; imem_addr = 32'h44;
      step();
      check("after_tmo_grant", {101'd0, mem_re, mem_addr}, {101'd0, 1'b1, 32'h44});
      step();
      mem_ready = 1'b1; mem_data_out = 32'h11112222;
      step();
      check("after_tmo_done", {100'd0, imem_ready, bus_err, imem_rdata},
            {100'd0, 1'b1, 1'b0, 32'h11112222});
      idle_inputs();
      step();

      // ---------------- boundary race ----------------
      imem_req = 1'b1; imem_addr = 32'h80;
      hi_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (mem_re) hi_cnt++;
      end
      check("race_re_cycles", 134'(hi_cnt), 134'd4);
      mem_ready = 1'b1; mem_data_out = 32'hABCD0001;
      step();
      check("race_done", {100'd0, imem_ready, bus_err, imem_rdata},
            {100'd0, 1'b1, 1'b0, 32'hABCD0001});
      idle_inputs();
      step();

      // ---------------- reset mid-transaction ----------------
      dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h2222; dmem_wdata = 32'h77;
      step();
      check("rst_pre_grant", {132'd0, dmem_owns, mem_wr}, {132'd0, 2'b11});
      step();
      #3 rst = 1'b0;
      #1;
      check("rst_async_clear", obs(), 134'd0);
      imem_req = 1'b1; imem_addr = 32'h10;
      dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h20;
      step();
      check("rst_held", obs(), 134'd0);
      #3 rst = 1'b1;
      step();
      check("rst_tie_dmem", {100'd0, dmem_owns, mem_re, mem_addr},
            {100'd0, 1'b1, 1'b1, 32'h20});
      idle_inputs();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequencing arbiter that shares the processor's single external memory port between the instruction-fetch requester (imem, read-only) and the load/store requester (dmem, read/write).
- Sits between the fetch/decode stages and the top-level memory pins, in the slot of the combinational bus mux.
- Adds a request/grant FSM, round-robin fairness, registered memory-side signals and a per-transaction timeout.

Parameters:
TIMEOUT  255  cycles to wait for mem_ready before aborting; legal range 1..255; counter is 8 bits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
imem_req  input  1  fetch request, held high until imem_ready
imem_addr  input  32  fetch address, stable while imem_req high
imem_rdata  output  32  fetched word, valid while imem_ready high
imem_ready  output  1  one-cycle completion pulse to fetch
dmem_req  input  1  load/store request, held high until dmem_ready
dmem_we  input  1  1 = store, 0 = load
dmem_addr  input  32  load/store address
dmem_wdata  input  32  store data
dmem_rdata  output  32  load data, valid while dmem_ready high
dmem_ready  output  1  one-cycle completion pulse to load/store
mem_addr  output  32  address to memory, registered
mem_data_in  output  32  write data to memory, registered
mem_wr  output  1  memory write strobe, registered
mem_re  output  1  memory read strobe, registered
mem_data_out  input  32  read data from memory
mem_ready  input  1  memory completion, one-cycle pulse
dmem_owns  output  1  high while the dmem transaction owns the bus
bus_err  output  1  pulses with the requester's ready when a transaction timed out

Behaviour:
- Reset (rst low, async): state=IDLE; every output 0; last_owner=IMEM; timeout counter 0. Any in-flight transaction is dropped with no ready pulse. Bus is usable on the first rising edge after rst goes high.
- States: IDLE, IMEM_BUSY, DMEM_BUSY.
- Request masking: a requester's req is ignored in the cycle its own ready output is high. This prevents a duplicate grant before the requester deasserts req.
- IDLE transitions:
  - only effective dmem_req -> DMEM_BUSY.
  - only effective imem_req -> IMEM_BUSY.
  - both -> grant the requester that is not last_owner; after reset dmem wins the first tie.
  - none -> stay in IDLE.
- Grant edge (registered, takes effect the next cycle):
  - mem_addr <= requester addr.
  - IMEM grant: mem_re=1, mem_wr=0.
  - DMEM grant: mem_re=~dmem_we, mem_wr=dmem_we, mem_data_in <= dmem_wdata, dmem_owns=1.
  - last_owner updated; counter cleared.
- BUSY states:
  - memory-side outputs are held constant.
  - mem_ready sampled high -> next cycle: strobes and dmem_owns drop to 0; owner's rdata <= mem_data_out (0 for stores); owner's ready=1 for one cycle; state=IDLE.
  - Counter increments every BUSY cycle without mem_ready. Reaching TIMEOUT -> same exit path, but rdata=0 and bus_err=1 for that one cycle.
  - mem_ready in the same cycle the counter reaches TIMEOUT -> normal completion, no bus_err.
- mem_ready while in IDLE is ignored; no output changes.
- Latency: effective req sampled at edge 0 -> strobe high after edge 0. mem_ready sampled at edge N -> ready/rdata high after edge N, for exactly one cycle. Next grant earliest at the following edge, giving 1 idle bus cycle between transactions.
- Outputs not belonging to the active transaction stay 0: the non-owner's ready, and rdata outside its ready cycle.
- A req deasserted mid-transaction does not abort it; completion still pulses ready.

Test Plan:
- Single fetch: imem_req=1, imem_addr=0x100; memory returns 0x00500093 with mem_ready 3 cycles after mem_re rises -> mem_re high for 3 cycles, imem_rdata=0x00500093 with a 1-cycle imem_ready, dmem_owns=0 throughout.
- Store: dmem_req=1, we=1, addr=0x2000, wdata=0xDEADBEEF -> mem_wr=1, mem_re=0, mem_data_in=0xDEADBEEF, dmem_owns=1 until completion; dmem_rdata=0 on dmem_ready.
- Contention: both req high from reset and held, addresses 0x10/0x20, memory latency 1 -> grant order dmem, imem, dmem, imem; 1 idle bus cycle between each; no duplicate grant.
- Timeout: TIMEOUT=4, imem request, mem_ready never asserted -> mem_re high 4 cycles, then imem_ready=1 with bus_err=1 and imem_rdata=0; a later request is served normally.
- Boundary race: mem_ready arrives on the cycle the counter reaches TIMEOUT -> completes with memory data, bus_err stays 0.
- Reset mid-transaction: rst low during DMEM_BUSY -> all outputs 0 immediately without waiting for clk; after release, a pending imem_req and dmem_req tie is granted to dmem first.
